// File: rtl/io_poll_master.sv
// Polls the 24-bit switch value over the IO bus and mirrors changes to the LED registers. A sequence takes 3 cycles, or 5 when the value changed.
// There is no backpressure: the bus answers in the same cycle, and force_i requests made while busy collapse into one pending poll.
module io_poll_master #(
   parameter logic [31:0] POLL_DIV   = 32'd50000,
   parameter logic [31:0] SW_LO_ADDR = 32'hFFFFF070,
   parameter logic [31:0] SW_HI_ADDR = 32'hFFFFF072,
   parameter logic [31:0] LT_LO_ADDR = 32'hFFFFF060,
   parameter logic [31:0] LT_HI_ADDR = 32'hFFFFF062
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        en_i,
   input  logic        force_i,
   output logic [31:0] addr_o,
   output logic        we_o,
   output logic [31:0] wr_data_o,
   input  logic [31:0] rd_data_i,
   output logic [23:0] sw_o,
   output logic        changed_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CMP, WR_LO, WR_HI} state_t;

   state_t      state_q, state_nx;
   logic [31:0] cnt_q, cnt_nx;
   logic        pend_q, pend_nx;
   logic        first_q, first_nx;
   logic [15:0] new_lo_q, new_lo_nx;
   logic [7:0]  new_hi_q, new_hi_nx;
   logic [23:0] new_val;
   logic [23:0] sw_nx;
   logic        changed_nx;
   logic [31:0] addr_nx, wdat_nx;
   logic        we_nx;
   logic        unused_rd_bits;

   assign new_val        = {new_hi_q, new_lo_q};
   assign unused_rd_bits = ^rd_data_i[31:16];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         first_q   <= 1'b1;
         new_lo_q  <= '0;
         new_hi_q  <= '0;
         sw_o      <= '0;
         changed_o <= 1'b0;
         addr_o    <= '0;
         we_o      <= 1'b0;
         wr_data_o <= '0;
         busy_o    <= 1'b0;
      end else begin
         state_q   <= state_nx;
         cnt_q     <= cnt_nx;
         pend_q    <= pend_nx;
         first_q   <= first_nx;
         new_lo_q  <= new_lo_nx;
         new_hi_q  <= new_hi_nx;
         sw_o      <= sw_nx;
         changed_o <= changed_nx;
         addr_o    <= addr_nx;
         we_o      <= we_nx;
         wr_data_o <= wdat_nx;
         busy_o    <= (state_nx != IDLE);
      end
   end

   always_comb begin
      state_nx   = state_q;
      cnt_nx     = '0;
      pend_nx    = pend_q | (force_i && (state_q != IDLE));
      first_nx   = first_q;
      new_lo_nx  = new_lo_q;
      new_hi_nx  = new_hi_q;
      sw_nx      = sw_o;
      changed_nx = 1'b0;

      case (state_q)
         IDLE: begin
            if (en_i) cnt_nx = cnt_q + 32'd1;
            if ((en_i && (cnt_q == POLL_DIV - 32'd1)) || force_i || pend_q) begin
               cnt_nx   = '0;
               pend_nx  = 1'b0;
               state_nx = RD_LO;
            end
         end
         RD_LO: begin
            new_lo_nx = rd_data_i[15:0];
            state_nx  = RD_HI;
         end
         RD_HI: begin
            new_hi_nx = rd_data_i[7:0];
            state_nx  = CMP;
         end
         CMP: begin
            if ((new_val != sw_o) || first_q) begin
               sw_nx      = new_val;
               changed_nx = 1'b1;
               first_nx   = 1'b0;
               state_nx   = WR_LO;
            end else begin
               state_nx = IDLE;
            end
         end
         WR_LO:   state_nx = WR_HI;
         WR_HI:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Bus outputs are decoded from the next state so they are registered yet valid for the whole state cycle.
   always_comb begin
      addr_nx = '0;
      we_nx   = 1'b0;
      wdat_nx = '0;
      case (state_nx)
         RD_LO: addr_nx = SW_LO_ADDR;
         RD_HI: addr_nx = SW_HI_ADDR;
         WR_LO: begin
            addr_nx = LT_LO_ADDR;
            we_nx   = 1'b1;
            wdat_nx = {16'h0, sw_nx[15:0]};
         end
         WR_HI: begin
            addr_nx = LT_HI_ADDR;
            we_nx   = 1'b1;
            wdat_nx = {24'h0, sw_nx[23:16]};
         end
         default: ;
      endcase
   end

endmodule
